// File: rtl/arbitor_core_if.sv
// rtl/arbitor_core_if.sv - request/grant/status bundle between arbiter core and its clients
interface arbitor_core_if #(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [OWN_W-1:0]   owner;
    logic               busy;
    logic               timeout_pulse;
    logic [31:0]        status;

    modport master (
        output req,
        input  grant, owner, busy, timeout_pulse, status
    );

    modport slave (
        input  req,
        output grant, owner, busy, timeout_pulse, status
    );
endinterface

// File: rtl/arbitor_core.sv
// rtl/arbitor_core.sv - four-requester round-robin / fixed-priority arbiter with hold limit and stats
module arbitor_core #(
    parameter int NUM_REQ = 4,
    parameter int HOLD_W  = 8
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_enable,
    input  logic               cfg_mode,
    input  logic               cfg_clr_stats,
    input  logic [HOLD_W-1:0]  cfg_max_hold,
    input  logic [NUM_REQ-1:0] cfg_mask,
    arbitor_core_if.slave      bus
);
    localparam int OWN_W = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [7:0]         tcnt_q, tcnt_d;
    logic [15:0]        total_q, total_d;
    logic               tpulse_q, tpulse_d;
    logic               sync_q;

    logic [NUM_REQ-1:0] ereq;
    logic [OWN_W-1:0]   rr_win, fp_win, win, idx;
    logic               rr_found;
    logic               hold_hit;
    logic               tcnt_inc, total_inc;
    logic               busy;

    assign ereq     = bus.req & ~cfg_mask;
    assign hold_hit = (cfg_max_hold != '0) && (hold_q == cfg_max_hold - HOLD_W'(1));

    // Round-robin searches owner+1 upward; the current owner is examined last.
    always_comb begin
        fp_win   = '0;
        rr_win   = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (ereq[i]) fp_win = OWN_W'(i);
        end
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = owner_q + OWN_W'(i);
            if (!rr_found && ereq[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
        end
        win = cfg_mode ? fp_win : rr_win;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        tpulse_d  = 1'b0;
        tcnt_inc  = 1'b0;
        total_inc = 1'b0;
        tcnt_d    = tcnt_q;
        total_d   = total_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (sync_q && cfg_enable && (ereq != '0)) begin
                    state_d   = ST_GRANT;
                    owner_d   = win;
                    grant_d   = NUM_REQ'(1) << win;
                    hold_d    = '0;
                    total_inc = 1'b1;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A voluntary release or disable takes precedence over a coincident timeout.
                if (!ereq[owner_q] || !cfg_enable) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (hold_hit) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    tpulse_d = 1'b1;
                    tcnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (cfg_clr_stats) begin
            tcnt_d  = '0;
            total_d = '0;
        end else begin
            if (tcnt_inc && (tcnt_q != 8'hFF)) tcnt_d = tcnt_q + 8'd1;
            total_d = total_q + {15'd0, total_inc};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '1;
            hold_q   <= '0;
            tcnt_q   <= '0;
            total_q  <= '0;
            tpulse_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            tcnt_q   <= tcnt_d;
            total_q  <= total_d;
            tpulse_q <= tpulse_d;
            sync_q   <= 1'b1;
        end
    end

    assign busy              = |grant_q;
    assign bus.grant         = grant_q;
    assign bus.owner         = owner_q;
    assign bus.busy          = busy;
    assign bus.timeout_pulse = tpulse_q;
    assign bus.status        = {total_q, tcnt_q, 1'b0, busy, owner_q, grant_q};
endmodule

// File: tb/tb_arbitor_core.sv
// tb/tb_arbitor_core.sv - directed and randomized bench for arbitor_core against a behavioural model
module tb_arbitor_core;
    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       cfg_enable;
    logic       cfg_mode;
    logic       cfg_clr_stats;
    logic [7:0] cfg_max_hold;
    logic [3:0] cfg_mask;

    arbitor_core_if #(.NUM_REQ(4)) bus_if ();

    arbitor_core #(.NUM_REQ(4), .HOLD_W(8)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .cfg_enable    (cfg_enable),
        .cfg_mode      (cfg_mode),
        .cfg_clr_stats (cfg_clr_stats),
        .cfg_max_hold  (cfg_max_hold),
        .cfg_mask      (cfg_mask),
        .bus           (bus_if)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_ready, m_busy, m_tp;
    int m_owner, m_len, m_tcnt, m_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_busy  = 1'b0;
        m_tp    = 1'b0;
        m_owner = 3;
        m_len   = 0;
        m_tcnt  = 0;
        m_total = 0;
    endtask

    function automatic int pick(input logic [3:0] e);
        if (cfg_mode) begin
            for (int i = 0; i < 4; i++) if (e[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (e[(m_owner + k) % 4]) return (m_owner + k) % 4;
        end
        return 0;
    endfunction

    // One clock edge of the arbitration rules, applied to the inputs held across that edge.
    task automatic model_step();
        logic [3:0] e;
        bit tinc, ginc;
        if (!ARESETN) begin
            model_reset();
        end else begin
            e    = bus_if.req & ~cfg_mask;
            m_tp = 1'b0;
            tinc = 1'b0;
            ginc = 1'b0;
            if (!m_ready) begin
                m_ready = 1'b1;
            end else if (!m_busy) begin
                if (cfg_enable && e != 4'd0) begin
                    m_owner = pick(e);
                    m_busy  = 1'b1;
                    m_len   = 1;
                    ginc    = 1'b1;
                end
            end else if (!e[m_owner] || !cfg_enable) begin
                m_busy = 1'b0;
            end else if (cfg_max_hold != 8'd0 && (m_len % 256) == int'(cfg_max_hold)) begin
                m_busy = 1'b0;
                m_tp   = 1'b1;
                tinc   = 1'b1;
            end else begin
                m_len++;
            end
            if (cfg_clr_stats) begin
                m_tcnt  = 0;
                m_total = 0;
            end else begin
                if (tinc && m_tcnt < 255) m_tcnt++;
                m_total = (m_total + int'(ginc)) % 65536;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant();
        return m_busy ? 4'(1 << m_owner) : 4'd0;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [3:0] g;
        g = exp_grant();
        return {m_total[15:0], m_tcnt[7:0], 1'b0, m_busy, m_owner[1:0], g};
    endfunction

    task automatic cycle();
        @(posedge ACLK);
        model_step();
        #1;
        check("grant", 32'(bus_if.grant), 32'(exp_grant()));
        check("status", bus_if.status, exp_status());
        check("tpulse", 32'(bus_if.timeout_pulse), 32'(m_tp));
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("rst_status", bus_if.status, 32'h0000_0030);
        ARESETN = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        ARESETN       = 1'b0;
        cfg_enable    = 1'b0;
        cfg_mode      = 1'b0;
        cfg_clr_stats = 1'b0;
        cfg_max_hold  = 8'd0;
        cfg_mask      = 4'd0;
        bus_if.req    = 4'd0;
        model_reset();
        @(negedge ACLK);
        do_reset();

        // Single requester: sync edge first, then grant with total=1.
        cfg_enable = 1'b1;
        bus_if.req = 4'b0100;
        cycle();
        check("t1_sync_nogrant", 32'(bus_if.grant), 32'd0);
        cycle();
        check("t1_grant", 32'(bus_if.grant), 32'h4);
        check("t1_status", bus_if.status, 32'h0001_0064);

        // Round-robin rotation under a 3-cycle hold limit.
        do_reset();
        cfg_max_hold = 8'd3;
        bus_if.req   = 4'b1111;
        cycle();
        for (int g = 0; g < 5; g++) begin
            cycle();
            check("t2_rr_grant", 32'(bus_if.grant), 32'(1 << (g % 4)));
            if (g < 4) begin
                repeat (3) cycle();
                check("t2_tpulse", 32'(bus_if.timeout_pulse), 32'd1);
                check("t2_gap", 32'(bus_if.grant), 32'd0);
            end
        end
        check("t2_tcnt", 32'(bus_if.status[15:8]), 32'd4);

        // Fixed priority with unlimited hold.
        do_reset();
        cfg_mode     = 1'b1;
        cfg_max_hold = 8'd0;
        bus_if.req   = 4'b1010;
        cycle();
        repeat (20) cycle();
        check("t3_fp_hold", 32'(bus_if.grant), 32'h2);
        bus_if.req = 4'b1000;
        cycle();
        check("t3_gap", 32'(bus_if.grant), 32'd0);
        cycle();
        check("t3_next", 32'(bus_if.grant), 32'h8);

        // Masking: masked request never granted; masking the owner ends its grant without a timeout.
        cfg_mask   = 4'b0001;
        bus_if.req = 4'b0001;
        repeat (5) cycle();
        check("t4_masked", 32'(bus_if.grant), 32'd0);
        cfg_mask   = 4'b0000;
        cfg_mode   = 1'b0;
        bus_if.req = 4'b0010;
        cycle();
        check("t4_grant1", 32'(bus_if.grant), 32'h2);
        cfg_mask = 4'b0010;
        cycle();
        check("t4_mask_drop", 32'(bus_if.grant), 32'd0);
        check("t4_tcnt", 32'(bus_if.status[15:8]), 32'd0);

        // Timeout counter saturation, then clear coinciding with a grant start.
        cfg_mask     = 4'b0000;
        cfg_max_hold = 8'd1;
        bus_if.req   = 4'b0001;
        repeat (600) cycle();
        check("t5_tcnt_sat", 32'(bus_if.status[15:8]), 32'hFF);
        if (m_busy) cycle();
        cfg_clr_stats = 1'b1;
        cycle();
        cfg_clr_stats = 1'b0;
        check("t5_clr_grant", 32'(bus_if.grant), 32'h1);
        check("t5_clr_stats", 32'(bus_if.status[31:8]), 32'd0);

        // Asynchronous reset in the middle of a grant.
        cfg_max_hold = 8'd0;
        bus_if.req   = 4'b1111;
        repeat (3) cycle();
        check("t6_busy", 32'(bus_if.busy), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("t6_async_grant", 32'(bus_if.grant), 32'd0);
        check("t6_async_status", bus_if.status, 32'h0000_0030);
        model_reset();
        cycle();
        ARESETN = 1'b1;
        cycle();
        check("t6_sync_nogrant", 32'(bus_if.grant), 32'd0);
        cycle();
        check("t6_first_grant", 32'(bus_if.grant), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom);
            if ($urandom_range(0, 40) == 0) cfg_mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 60) == 0) cfg_mode = ~cfg_mode;
            if ($urandom_range(0, 50) == 0) cfg_max_hold = 8'($urandom_range(0, 6));
            cfg_enable    = ($urandom_range(0, 30) != 0);
            cfg_clr_stats = ($urandom_range(0, 100) == 0);
            cycle();
        end
        cfg_clr_stats = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
